// File: rtl/noc_channel_mux.sv
// noc_channel_mux: per-channel flit FIFOs arbitrated packet-atomically onto one shared link
module noc_channel_mux #(
   parameter int FLIT_WIDTH = 32,
   parameter int CHANNELS   = 2,
   parameter int DEPTH      = 4,
   parameter int ARB_MODE   = 0,
   localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [CHANNELS*FLIT_WIDTH-1:0] in_flit,
   input  logic [CHANNELS-1:0]            in_last,
   input  logic [CHANNELS-1:0]            in_valid,
   output logic [CHANNELS-1:0]            in_ready,
   output logic [FLIT_WIDTH-1:0]          out_flit,
   output logic                           out_last,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [CW-1:0]                  out_channel
);
   localparam int aw = $clog2(DEPTH);
   localparam logic [aw:0] full_cnt = (aw+1)'(DEPTH);
   typedef enum logic {UNLOCKED, LOCKED} state_t;
   state_t state, state_nx;
   logic [FLIT_WIDTH:0] mem [CHANNELS][DEPTH];
   logic [aw-1:0] wr_ptr [CHANNELS];
   logic [aw-1:0] rd_ptr [CHANNELS];
   logic [aw:0] cnt [CHANNELS];
   logic [CHANNELS-1:0] empty, full, push, pop;
   logic [CW-1:0] grant, grant_nx, rr_ptr, rr_nx, cand, sel;
   logic found, xfer;
   logic [FLIT_WIDTH:0] head;
   int idx;
   // FIFO status; in_ready is held low while reset is asserted
   always_comb begin
      empty = '0;
      full = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         empty[i] = cnt[i] == '0;
         full[i] = cnt[i] == full_cnt;
      end
      in_ready = ~full & {CHANNELS{rst_n}};
      push = in_valid & in_ready;
   end
   // candidate search among non-empty channels: from rr_ptr upward, or lowest index first
   always_comb begin
      cand = '0;
      found = 1'b0;
      idx = 0;
      for (int i = 0; i < CHANNELS; i++) begin
         idx = (ARB_MODE == 0) ? (int'(rr_ptr) + i) % CHANNELS : i;
         if (!found && !empty[idx]) begin
            found = 1'b1;
            cand = CW'(idx);
         end
      end
   end
   // output mux: locked grant pins the source, otherwise the live candidate drives the link
   always_comb begin
      sel = (state == LOCKED) ? grant : cand;
      out_valid = (state == LOCKED) ? !empty[sel] : found;
      head = mem[sel][rd_ptr[sel]];
      out_flit = out_valid ? head[FLIT_WIDTH-1:0] : '0;
      out_last = out_valid & head[FLIT_WIDTH];
      out_channel = out_valid ? sel : grant;
   end
   // transfer handling: lock on a non-last flit, release and advance rr_ptr on a last flit
   always_comb begin
      xfer = out_valid && out_ready;
      state_nx = state;
      grant_nx = grant;
      rr_nx = rr_ptr;
      pop = '0;
      if (xfer) begin
         pop[sel] = 1'b1;
         grant_nx = sel;
         state_nx = head[FLIT_WIDTH] ? UNLOCKED : LOCKED;
         rr_nx = !head[FLIT_WIDTH] ? rr_ptr : (sel == CW'(CHANNELS-1)) ? '0 : sel + CW'(1);
      end
   end
   // arbiter state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= UNLOCKED;
         grant <= '0;
         rr_ptr <= '0;
      end else begin
         state <= state_nx;
         grant <= grant_nx;
         rr_ptr <= rr_nx;
      end
   end
   // FIFO pointers and occupancy; reset discards all buffered flits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + aw'(1);
            if (pop[i]) rd_ptr[i] <= rd_ptr[i] + aw'(1);
            if (push[i] != pop[i]) cnt[i] <= push[i] ? cnt[i] + (aw+1)'(1) : cnt[i] - (aw+1)'(1);
         end
      end
   end
   // FIFO storage holds {last, flit}; contents are masked by out_valid so need no reset
   always_ff @(posedge clk) begin
      for (int i = 0; i < CHANNELS; i++)
         if (push[i]) mem[i][wr_ptr[i]] <= {in_last[i], in_flit[i*FLIT_WIDTH +: FLIT_WIDTH]};
   end
endmodule

// File: tb/tb_noc_channel_mux.sv
// tb_noc_channel_mux: queue-model checker for a 2-channel round-robin and a 3-channel fixed-priority mux
module tb_noc_channel_mux;
   localparam int DEPTH = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [63:0] a_flit;
   logic [1:0]  a_last, a_valid, a_irdy;
   logic [31:0] a_of;
   logic        a_ol, a_ov, a_ordy;
   logic [0:0]  a_oc;
   logic [95:0] b_flit;
   logic [2:0]  b_last, b_valid, b_irdy;
   logic [31:0] b_of;
   logic        b_ol, b_ov, b_ordy;
   logic [1:0]  b_oc;

   noc_channel_mux #(.FLIT_WIDTH(32), .CHANNELS(2), .DEPTH(DEPTH), .ARB_MODE(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_flit(a_flit), .in_last(a_last), .in_valid(a_valid),
      .in_ready(a_irdy), .out_flit(a_of), .out_last(a_ol), .out_valid(a_ov),
      .out_ready(a_ordy), .out_channel(a_oc));
   noc_channel_mux #(.FLIT_WIDTH(32), .CHANNELS(3), .DEPTH(DEPTH), .ARB_MODE(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_flit(b_flit), .in_last(b_last), .in_valid(b_valid),
      .in_ready(b_irdy), .out_flit(b_of), .out_last(b_ol), .out_valid(b_ov),
      .out_ready(b_ordy), .out_channel(b_oc));

   int nch [2] = '{2, 3};
   int mode [2] = '{0, 1};
   logic [32:0] q [2][3][$];
   bit lk [2];
   int lch [2];
   int rr [2];
   int gr [2];
   typedef struct {logic [31:0] f; int ch; int cyc;} ent_t;
   ent_t lg [2][$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic int pick(int k);
      if (lk[k]) return q[k][lch[k]].size() > 0 ? lch[k] : -1;
      for (int i = 0; i < nch[k]; i++) begin
         int c;
         c = (mode[k] == 0) ? (rr[k] + i) % nch[k] : i;
         if (q[k][c].size() > 0) return c;
      end
      return -1;
   endfunction

   task automatic step(int k, logic [2:0] v, logic [2:0] l, logic [95:0] f, logic r);
      bit acc [3];
      int p;
      logic [32:0] d;
      for (int c = 0; c < nch[k]; c++) acc[c] = v[c] && q[k][c].size() < DEPTH;
      p = pick(k);
      if (p >= 0 && r) begin
         d = q[k][p].pop_front();
         gr[k] = p;
         if (d[32]) begin
            lk[k] = 1'b0;
            rr[k] = (p + 1) % nch[k];
         end else begin
            lk[k] = 1'b1;
            lch[k] = p;
         end
      end
      for (int c = 0; c < nch[k]; c++)
         if (acc[c]) q[k][c].push_back({l[c], f[c*32 +: 32]});
   endtask

   task automatic cmp_inst(int k, logic [2:0] ir, logic ov, logic [31:0] of, logic ol, int oc, logic r);
      int p;
      logic [2:0] eir;
      logic [32:0] h;
      p = rst_n ? pick(k) : -1;
      eir = '0;
      for (int c = 0; c < nch[k]; c++) eir[c] = rst_n && q[k][c].size() < DEPTH;
      chk($sformatf("in_ready%0d", k), ir, eir);
      chk($sformatf("out_valid%0d", k), ov, p >= 0);
      chk($sformatf("out_channel%0d", k), oc, (p >= 0) ? p : gr[k]);
      if (p >= 0) begin
         h = q[k][p][0];
         chk($sformatf("out_flit%0d", k), of, h[31:0]);
         chk($sformatf("out_last%0d", k), ol, h[32]);
      end else if (!rst_n) begin
         chk($sformatf("reset out_flit%0d", k), of, 0);
         chk($sformatf("reset out_last%0d", k), ol, 0);
      end
      if (rst_n && ov && r) lg[k].push_back('{of, oc, cyc});
   endtask

   always @(posedge clk) begin
      cyc++;
      if (rst_n) begin
         step(0, {1'b0, a_valid}, {1'b0, a_last}, {32'b0, a_flit}, a_ordy);
         step(1, b_valid, b_last, b_flit, b_ordy);
      end
   end

   always @(negedge clk) begin
      if (!rst_n)
         for (int k = 0; k < 2; k++) begin
            lk[k] = 1'b0;
            lch[k] = 0;
            rr[k] = 0;
            gr[k] = 0;
            for (int c = 0; c < 3; c++) q[k][c].delete();
         end
      cmp_inst(0, {1'b0, a_irdy}, a_ov, a_of, a_ol, int'(a_oc), a_ordy);
      cmp_inst(1, b_irdy, b_ov, b_of, b_ol, int'(b_oc), b_ordy);
   end

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_log(string nm, int k, int n, logic [31:0] ef [8], int ec [8], bit tight);
      chk({nm, " count"}, lg[k].size(), n);
      for (int i = 0; i < n && i < lg[k].size(); i++) begin
         chk($sformatf("%s flit%0d", nm, i), lg[k][i].f, ef[i]);
         chk($sformatf("%s chan%0d", nm, i), lg[k][i].ch, ec[i]);
         if (tight && i > 0) chk($sformatf("%s gap%0d", nm, i), lg[k][i].cyc - lg[k][i-1].cyc, 1);
      end
   endtask

   initial begin
      a_flit = '0; a_last = '0; a_valid = '0; a_ordy = 1'b0;
      b_flit = '0; b_last = '0; b_valid = '0; b_ordy = 1'b1;
      // reset held for three cycles
      tick(3);
      chk("reset in_ready a", a_irdy, 2'b00);
      chk("reset out_valid a", a_ov, 0);
      rst_n = 1'b1;
      #1;
      chk("release in_ready a", a_irdy, 2'b11);
      chk("release in_ready b", b_irdy, 3'b111);
      chk("release out_valid a", a_ov, 0);
      // round-robin across two 2-flit packets per channel
      a_ordy = 1'b1;
      lg[0].delete();
      for (int i = 0; i < 4; i++) begin
         a_valid = 2'b11;
         a_flit = {32'hC0 + 32'(16 * (i / 2) + i % 2), 32'hA0 + 32'(16 * (i / 2) + i % 2)};
         a_last = {2{i[0]}};
         tick(1);
      end
      a_valid = '0;
      tick(8);
      chk_log("rr", 0, 8, '{32'hA0, 32'hA1, 32'hC0, 32'hC1, 32'hB0, 32'hB1, 32'hD0, 32'hD1},
              '{0, 0, 1, 1, 0, 0, 1, 1}, 1'b1);
      // packet atomicity: ch0 stalls mid-packet while ch1 waits
      lg[0].delete();
      a_valid = 2'b11; a_flit = {32'hE0, 32'h10}; a_last = 2'b10;
      tick(1);
      a_valid = '0;
      tick(2);
      a_valid = 2'b01; a_flit = {32'h0, 32'h11}; a_last = 2'b01;
      tick(1);
      a_valid = '0;
      tick(4);
      chk_log("atom", 0, 3, '{32'h10, 32'h11, 32'hE0, 0, 0, 0, 0, 0}, '{0, 0, 1, 0, 0, 0, 0, 0}, 1'b0);
      if (lg[0].size() >= 2) chk("atom stall", lg[0][1].cyc - lg[0][0].cyc, 3);
      // fixed priority: ch0 keeps refilling ahead of ch1 and ch2
      lg[1].delete();
      b_valid = 3'b111; b_flit = {32'h320, 32'h310, 32'h300}; b_last = 3'b111;
      tick(1);
      b_valid = 3'b001; b_flit = {64'h0, 32'h301};
      tick(1);
      b_flit = {64'h0, 32'h302};
      tick(1);
      b_valid = '0;
      tick(6);
      chk_log("fp", 1, 5, '{32'h300, 32'h301, 32'h302, 32'h310, 32'h320, 0, 0, 0},
              '{0, 0, 0, 1, 2, 0, 0, 0}, 1'b1);
      // backpressure: fill ch0, hold a fifth flit off, then drain
      lg[0].delete();
      a_ordy = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         a_valid = 2'b01; a_flit = {32'h0, 32'h40 + 32'(i)}; a_last = 2'b00;
         tick(1);
      end
      a_flit = {32'h0, 32'h45}; a_last = 2'b01;
      chk("full in_ready", a_irdy[0], 0);
      tick(2);
      chk("held in_ready", a_irdy[0], 0);
      a_ordy = 1'b1;
      tick(1);
      chk("pop in_ready", a_irdy[0], 1);
      tick(1);
      a_valid = '0;
      tick(6);
      chk_log("bp", 0, 5, '{32'h41, 32'h42, 32'h43, 32'h44, 32'h45, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b1);
      // reset in the middle of a 3-flit packet
      lg[0].delete();
      a_valid = 2'b01; a_flit = {32'h0, 32'h50}; a_last = 2'b00;
      tick(1);
      a_flit = {32'h0, 32'h51};
      tick(1);
      rst_n = 1'b0;
      a_valid = '0;
      #1;
      chk("mid reset in_ready", a_irdy, 2'b00);
      chk("mid reset out_valid", a_ov, 0);
      tick(2);
      rst_n = 1'b1;
      #1;
      chk("post reset in_ready", a_irdy, 2'b11);
      chk("post reset out_valid", a_ov, 0);
      tick(3);
      a_valid = 2'b10; a_flit = {32'h60, 32'h0}; a_last = 2'b10;
      tick(1);
      a_valid = '0;
      tick(3);
      chk_log("rst", 0, 2, '{32'h50, 32'h60, 0, 0, 0, 0, 0, 0}, '{0, 1, 0, 0, 0, 0, 0, 0}, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
